i2c_reg_target: RTL



---
 rtl/i2c_target_pkg.sv | 22 ++
 rtl/i2c_line_filter.sv | 54 +++++
 rtl/i2c_reg_target.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_target_pkg;

    localparam int DATA_W   = 8;
    localparam int BITCNT_W = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer plus run-length filter for one I2C line.
// The filtered level moves only after FILT consecutive samples disagree with it.
module i2c_line_filter #(
    parameter int unsigned FILT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);

    logic       sync0_r;
    logic       sync1_r;
    logic       level_r;
    logic [3:0] cnt_r;
    logic       rise_r;
    logic       fall_r;

    // Synchronize the pin and accept a new level once it has been stable long enough.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync0_r <= 1'b1;
            sync1_r <= 1'b1;
            level_r <= 1'b1;
            cnt_r   <= 4'd0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync0_r <= pin;
            sync1_r <= sync0_r;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            if (sync1_r == level_r) begin
                cnt_r <= 4'd0;
            end else if (cnt_r == FILT_LAST) begin
                level_r <= sync1_r;
                cnt_r   <= 4'd0;
                rise_r  <= sync1_r;
                fall_r  <= ~sync1_r;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing a 256 x 8 register window at a fixed 7-bit address.
// Open-drain SDA; never stretches SCL; REG_ADDR persists across transactions.
module i2c_reg_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  ADDR = 7'h39,
    parameter int unsigned FILT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I2C_SCL,
    inout  wire         I2C_SDA,
    output logic [7:0]  REG_ADDR,
    output logic [7:0]  REG_WDATA,
    output logic        REG_WE,
    input  logic [7:0]  REG_RDATA,
    output logic        BUSY
);

    logic scl_f_s, scl_rise_s, scl_fall_s;
    logic sda_f_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [DATA_W-1:0] rx_byte_s;

    i2c_target_pkg::i2c_state_e state_r, state_s;
    logic [BITCNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0]   shift_r, shift_s;
    logic [DATA_W-1:0]   reg_addr_r, reg_addr_s;
    logic [DATA_W-1:0]   reg_wdata_r, reg_wdata_s;
    logic byte_done_r, byte_done_s;
    logic sda_oe_r, sda_oe_s;
    logic reg_we_r, reg_we_s;
    logic inc_pend_r, inc_pend_s;
    logic busy_r, busy_s;
    logic rw_r, rw_s;
    logic mack_r, mack_s;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .CLK   (CLK),
        .RESET (RESET),
        .pin   (I2C_SCL),
        .level (scl_f_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .CLK   (CLK),
        .RESET (RESET),
        .pin   (I2C_SDA),
        .level (sda_f_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    // An SDA edge coinciding with an SCL fall is not a bus condition (e.g. just after reset).
    assign start_s   = sda_fall_s & scl_f_s & ~scl_fall_s;
    assign stop_s    = sda_rise_s & scl_f_s & ~scl_fall_s;
    assign rx_byte_s = {shift_r[6:0], sda_f_s};

    // Next-state and next-output logic for the bus protocol.
    always_comb begin
        state_s     = state_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        byte_done_s = byte_done_r;
        sda_oe_s    = sda_oe_r;
        reg_wdata_s = reg_wdata_r;
        reg_we_s    = 1'b0;
        inc_pend_s  = 1'b0;
        busy_s      = busy_r;
        rw_s        = rw_r;
        mack_s      = mack_r;
        if (inc_pend_r) begin
            reg_addr_s = reg_addr_r + 8'd1;
        end else begin
            reg_addr_s = reg_addr_r;
        end

        if (start_s) begin
            state_s     = ST_ADDR;
            bit_cnt_s   = 3'd0;
            byte_done_s = 1'b0;
            sda_oe_s    = 1'b0;
            busy_s      = 1'b0;
        end else if (stop_s) begin
            state_s     = ST_IDLE;
            bit_cnt_s   = 3'd0;
            byte_done_s = 1'b0;
            sda_oe_s    = 1'b0;
            busy_s      = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sda_oe_s = 1'b0;
                end
                ST_ADDR: begin
                    if (scl_rise_s && !byte_done_r) begin
                        shift_s     = rx_byte_s;
                        bit_cnt_s   = bit_cnt_r + 3'd1;
                        byte_done_s = (bit_cnt_r == 3'd7);
                    end else if (scl_fall_s && byte_done_r) begin
                        byte_done_s = 1'b0;
                        if (shift_r[7:1] == ADDR) begin
                            state_s  = ST_ADDR_ACK;
                            sda_oe_s = 1'b1;
                            busy_s   = 1'b1;
                            rw_s     = shift_r[0];
                        end else begin
                            state_s  = ST_IDLE;
                            sda_oe_s = 1'b0;
                        end
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_s = 3'd0;
                        if (rw_r) begin
                            state_s  = ST_RDATA;
                            shift_s  = REG_RDATA;
                            sda_oe_s = ~REG_RDATA[7];
                        end else begin
                            state_s  = ST_SUB;
                            sda_oe_s = 1'b0;
                        end
                    end else begin
                        state_s = ST_ADDR_ACK;
                    end
                end
                ST_SUB: begin
                    if (scl_rise_s && !byte_done_r) begin
                        shift_s     = rx_byte_s;
                        bit_cnt_s   = bit_cnt_r + 3'd1;
                        byte_done_s = (bit_cnt_r == 3'd7);
                        if (bit_cnt_r == 3'd7) begin
                            reg_addr_s = rx_byte_s;
                        end else begin
                            reg_addr_s = reg_addr_r;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        state_s     = ST_SUB_ACK;
                        sda_oe_s    = 1'b1;
                        byte_done_s = 1'b0;
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall_s) begin
                        state_s   = ST_WDATA;
                        sda_oe_s  = 1'b0;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_WDATA: begin
                    if (scl_rise_s && !byte_done_r) begin
                        shift_s     = rx_byte_s;
                        bit_cnt_s   = bit_cnt_r + 3'd1;
                        byte_done_s = (bit_cnt_r == 3'd7);
                        if (bit_cnt_r == 3'd7) begin
                            reg_wdata_s = rx_byte_s;
                            reg_we_s    = 1'b1;
                            inc_pend_s  = 1'b1;
                        end else begin
                            reg_wdata_s = reg_wdata_r;
                        end
                    end else if (scl_fall_s && byte_done_r) begin
                        state_s     = ST_WDATA_ACK;
                        sda_oe_s    = 1'b1;
                        byte_done_s = 1'b0;
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_RDATA: begin
                    // The bit on the wire is shift_r[7]; it is shifted out once the controller samples it.
                    if (scl_rise_s && !byte_done_r) begin
                        shift_s     = {shift_r[6:0], 1'b0};
                        bit_cnt_s   = bit_cnt_r + 3'd1;
                        byte_done_s = (bit_cnt_r == 3'd7);
                    end else if (scl_fall_s) begin
                        if (byte_done_r) begin
                            state_s     = ST_RDATA_ACK;
                            sda_oe_s    = 1'b0;
                            byte_done_s = 1'b0;
                        end else begin
                            sda_oe_s = ~shift_r[7];
                        end
                    end else begin
                        shift_s = shift_r;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise_s) begin
                        mack_s     = sda_f_s;
                        inc_pend_s = (sda_f_s == I2C_ACK);
                    end else if (scl_fall_s) begin
                        bit_cnt_s = 3'd0;
                        if (mack_r == I2C_ACK) begin
                            state_s  = ST_RDATA;
                            shift_s  = REG_RDATA;
                            sda_oe_s = ~REG_RDATA[7];
                        end else begin
                            state_s  = ST_IDLE;
                            sda_oe_s = 1'b0;
                        end
                    end else begin
                        mack_s = mack_r;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    sda_oe_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            byte_done_r <= 1'b0;
            sda_oe_r    <= 1'b0;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
            reg_we_r    <= 1'b0;
            inc_pend_r  <= 1'b0;
            busy_r      <= 1'b0;
            rw_r        <= 1'b0;
            mack_r      <= I2C_NACK;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            byte_done_r <= byte_done_s;
            sda_oe_r    <= sda_oe_s;
            reg_addr_r  <= reg_addr_s;
            reg_wdata_r <= reg_wdata_s;
            reg_we_r    <= reg_we_s;
            inc_pend_r  <= inc_pend_s;
            busy_r      <= busy_s;
            rw_r        <= rw_s;
            mack_r      <= mack_s;
        end
    end

    assign I2C_SDA   = sda_oe_r ? 1'b0 : 1'bz;
    assign REG_ADDR  = reg_addr_r;
    assign REG_WDATA = reg_wdata_r;
    assign REG_WE    = reg_we_r;
    assign BUSY      = busy_r;

endmodule
